intpol2_d4_ch_sched: RTL

Round-robin job scheduler that shares one intpol2_D4 interpolator core between N_CH input/output FIFO channel pairs.
- Picks the next eligible channel.
- Steers the core's FIFO muxes to it.
- Issues a one-cycle start and waits for the core's done pulse.
- Aborts and masks any channel whose job exceeds a programmable timeout.
- Sits between the per-channel FIFOs and the single core instance.

---
 rtl/intpol2_d4_ch_sched_pkg.sv | 26 ++
 rtl/intpol2_d4_ch_sched_rr_arb.sv | 33 +++
 rtl/intpol2_d4_ch_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/intpol2_d4_ch_sched_pkg.sv
// Shared types and helpers for the intpol2_D4 channel scheduler.
// Holds the FSM state encoding, the pointer reset value and clog2.
package intpol2_D4_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARB   = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_GAP   = 3'd4
   } sched_state_e;

   // Width of an index able to address n entries (at least 1 bit).
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

   // Pointer resets to the last channel so channel 0 wins first.
   function automatic int rr_ptr_rst(input int n_ch);
      return n_ch - 1;
   endfunction

endpackage

// File: rtl/intpol2_d4_ch_sched_rr_arb.sv
// Combinational round-robin picker: first request after ptr_i, wrapping.
// Ports: req_i request vector, ptr_i last grant, grant_valid_o, grant_idx_o.
module intpol2_D4_rr_arb
   import intpol2_D4_sched_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CH_W = clog2(N_CH)
) (
   input  logic [N_CH-1:0] req_i,
   input  logic [CH_W-1:0] ptr_i,
   output logic            grant_valid_o,
   output logic [CH_W-1:0] grant_idx_o
);

   always_comb begin
      int            idx;
      logic [CH_W-1:0] sel;
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      idx           = 0;
      sel           = '0;
      // Walk farthest-to-nearest so the nearest hit after ptr_i wins.
      for (int k = N_CH; k >= 1; k--) begin
         idx = (int'(ptr_i) + k) % N_CH;
         sel = CH_W'(idx);
         if (req_i[sel]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = sel;
         end
      end
   end

endmodule

// File: rtl/intpol2_d4_ch_sched.sv
// Round-robin job scheduler sharing one intpol2_D4 core among N_CH channels.
// In: enable, ch_en/bypass/empty/afull, tmo_limit, err_clr, core_done.
// Out: core_start/abort/bypass, ch_sel, sched_busy, timeout_err, err_ch, ch_mask.
module intpol2_d4_ch_sched
   import intpol2_D4_sched_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CH_W  = clog2(N_CH),
   parameter int TMO_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic [N_CH-1:0]  ch_en,
   input  logic [N_CH-1:0]  ch_bypass,
   input  logic [N_CH-1:0]  ch_empty,
   input  logic [N_CH-1:0]  ch_afull,
   input  logic [TMO_W-1:0] tmo_limit,
   input  logic             err_clr,
   input  logic             core_done,
   output logic             core_start,
   output logic             core_abort,
   output logic             core_bypass,
   output logic [CH_W-1:0]  ch_sel,
   output logic             sched_busy,
   output logic             timeout_err,
   output logic [CH_W-1:0]  err_ch,
   output logic [N_CH-1:0]  ch_mask
);

   localparam logic [CH_W-1:0] PTR_RST = CH_W'(rr_ptr_rst(N_CH));

   sched_state_e     state_q, state_d;
   logic [CH_W-1:0]  ptr_q;
   logic [CH_W-1:0]  sel_q;
   logic             byp_q;
   logic [TMO_W-1:0] cnt_q;
   logic             err_q;
   logic [CH_W-1:0]  err_ch_q;
   logic [N_CH-1:0]  mask_q;

   logic [N_CH-1:0]  elig;
   logic [N_CH-1:0]  sel_oh;
   logic             gnt_vld;
   logic [CH_W-1:0]  gnt_idx;
   logic             take;
   logic             tmo_hit;

   assign elig   = ch_en & ~ch_empty & ~ch_afull & ~mask_q;
   assign sel_oh = N_CH'(1) << sel_q;

   intpol2_D4_rr_arb #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_arb (
      .req_i         (elig),
      .ptr_i         (ptr_q),
      .grant_valid_o (gnt_vld),
      .grant_idx_o   (gnt_idx)
   );

   // Done in the same cycle as the limit wins, so it masks the timeout.
   assign tmo_hit = (state_q == ST_RUN) && !core_done
                 && (tmo_limit != '0)
                 && (cnt_q == tmo_limit - TMO_W'(1));

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (gnt_vld) begin
               take    = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: state_d = ST_RUN;
         ST_RUN: begin
            if (core_done || tmo_hit) state_d = ST_GAP;
         end
         ST_GAP: state_d = enable ? ST_ARB : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         ptr_q   <= PTR_RST;
         sel_q   <= '0;
         byp_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            ptr_q <= gnt_idx;
            sel_q <= gnt_idx;
            byp_q <= ch_bypass[gnt_idx];
         end
         if (state_q == ST_START) begin
            cnt_q <= '0;
         end else if (state_q == ST_RUN && cnt_q != '1) begin
            cnt_q <= cnt_q + TMO_W'(1);
         end
      end
   end

   // A new timeout beats a simultaneous clear: only the new bit survives.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q    <= 1'b0;
         err_ch_q <= '0;
         mask_q   <= '0;
      end else if (tmo_hit) begin
         err_q    <= 1'b1;
         err_ch_q <= sel_q;
         mask_q   <= err_clr ? sel_oh : (mask_q | sel_oh);
      end else if (err_clr) begin
         err_q  <= 1'b0;
         mask_q <= '0;
      end
   end

   assign core_start  = (state_q == ST_START);
   assign core_abort  = tmo_hit;
   assign sched_busy  = (state_q == ST_START) || (state_q == ST_RUN)
                     || (state_q == ST_GAP);
   assign core_bypass = byp_q;
   assign ch_sel      = sel_q;
   assign timeout_err = err_q;
   assign err_ch      = err_ch_q;
   assign ch_mask     = mask_q;

endmodule
